// File: rtl/ui_device_responder.sv
// Board-side responder for the UI bus: HEX/LEDR output registers, synchronised and
// debounced KEY/SW inputs with sticky key-press flags, and a combinational read mux.
module ui_device_responder #(
    parameter int         DBITS           = 32,
    parameter int         NKEYS           = 4,
    parameter int         NSW             = 10,
    parameter int         NLEDR           = 10,
    parameter int         DEBOUNCE_CYCLES = 50000,
    parameter logic [1:0] DEV_HEX         = 2'd0,
    parameter logic [1:0] DEV_LEDR        = 2'd1,
    parameter logic [1:0] DEV_KEY         = 2'd2,
    parameter logic [1:0] DEV_SW          = 2'd3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       uiDevice,
    input  logic             uiWrtEn,
    input  logic [DBITS-1:0] uiOut,
    output logic [DBITS-1:0] uiIn,
    input  logic [NKEYS-1:0] KEY,
    input  logic [NSW-1:0]   SW,
    output logic [6:0]       HEX0,
    output logic [6:0]       HEX1,
    output logic [6:0]       HEX2,
    output logic [6:0]       HEX3,
    output logic [NLEDR-1:0] LEDR
);

    // KEY and SW share one debounce path; KEY occupies the low bits and is active-low.
    localparam int            NIN      = NKEYS + NSW;
    localparam int            CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [NIN-1:0] PIN_INV = {{NSW{1'b0}}, {NKEYS{1'b1}}};

    logic [NIN-1:0]   sync1, sync2, sync_val;
    logic [NIN-1:0]   lvl, lvl_next;
    logic [CW-1:0]    cnt      [NIN];
    logic [CW-1:0]    cnt_next [NIN];
    logic [NKEYS-1:0] key_lvl, key_hit, key_rise, key_clr;
    logic [NSW-1:0]   sw_lvl;
    logic [15:0]      hex_reg;
    logic [NLEDR-1:0] ledr_reg;
    logic             unused_bits;

    function automatic logic [6:0] hex_glyph(input logic [3:0] d);
        case (d)
            4'h0: hex_glyph = 7'h40;
            4'h1: hex_glyph = 7'h79;
            4'h2: hex_glyph = 7'h24;
            4'h3: hex_glyph = 7'h30;
            4'h4: hex_glyph = 7'h19;
            4'h5: hex_glyph = 7'h12;
            4'h6: hex_glyph = 7'h02;
            4'h7: hex_glyph = 7'h78;
            4'h8: hex_glyph = 7'h00;
            4'h9: hex_glyph = 7'h10;
            4'hA: hex_glyph = 7'h08;
            4'hB: hex_glyph = 7'h03;
            4'hC: hex_glyph = 7'h46;
            4'hD: hex_glyph = 7'h21;
            4'hE: hex_glyph = 7'h06;
            default: hex_glyph = 7'h0E;
        endcase
    endfunction

    assign sync_val = sync2 ^ PIN_INV;

    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    always_comb begin
        lvl_next = lvl;
        for (int i = 0; i < NIN; i++) begin
            cnt_next[i] = '0;
            if (sync_val[i] != lvl[i]) begin
                if (cnt[i] == CNT_LAST) lvl_next[i] = sync_val[i];
                else                    cnt_next[i] = cnt[i] + CW'(1);
            end
        end
    end

    assign key_lvl  = lvl[NKEYS-1:0];
    assign sw_lvl   = lvl[NIN-1:NKEYS];
    assign key_rise = lvl_next[NKEYS-1:0] & ~key_lvl;
    assign key_clr  = (uiWrtEn && uiDevice == DEV_KEY) ? uiOut[4 +: NKEYS] : '0;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1    <= PIN_INV;
            sync2    <= PIN_INV;
            lvl      <= '0;
            key_hit  <= '0;
            hex_reg  <= '0;
            ledr_reg <= '0;
            for (int i = 0; i < NIN; i++) cnt[i] <= '0;
        end else begin
            sync1   <= {SW, KEY};
            sync2   <= sync1;
            lvl     <= lvl_next;
            for (int i = 0; i < NIN; i++) cnt[i] <= cnt_next[i];
            // A press on the same edge as a write-clear keeps the flag set.
            key_hit <= (key_hit & ~key_clr) | key_rise;
            if (uiWrtEn && uiDevice == DEV_HEX)  hex_reg  <= uiOut[15:0];
            if (uiWrtEn && uiDevice == DEV_LEDR) ledr_reg <= uiOut[NLEDR-1:0];
        end
    end

    always_comb begin
        uiIn = '0;
        case (uiDevice)
            DEV_HEX:  uiIn[15:0] = hex_reg;
            DEV_LEDR: uiIn[NLEDR-1:0] = ledr_reg;
            DEV_KEY: begin
                uiIn[4 +: NKEYS] = key_hit;
                uiIn[0 +: NKEYS] = key_lvl;
            end
            DEV_SW:   uiIn[NSW-1:0] = sw_lvl;
            default:  ;
        endcase
    end

    assign HEX0        = hex_glyph(hex_reg[3:0]);
    assign HEX1        = hex_glyph(hex_reg[7:4]);
    assign HEX2        = hex_glyph(hex_reg[11:8]);
    assign HEX3        = hex_glyph(hex_reg[15:12]);
    assign LEDR        = ledr_reg;
    assign unused_bits = ^uiOut;

endmodule

// File: tb/tb_ui_device_responder.sv
// Randomised and directed bench for ui_device_responder with a behavioural reference
// model (delayed pin samples plus per-bit disagreement run lengths) checked every cycle.
module tb_ui_device_responder;

    localparam int DEB = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  uiDevice;
    logic        uiWrtEn;
    logic [31:0] uiOut;
    logic [31:0] uiIn;
    logic [3:0]  KEY;
    logic [9:0]  SW;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3;
    logic [9:0]  LEDR;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    // Reference model state
    logic [15:0] m_hex;
    logic [9:0]  m_ledr;
    logic [3:0]  m_key_lvl, m_key_hit;
    logic [9:0]  m_sw_lvl;
    logic [13:0] seen_q[$];
    int          run[14];

    ui_device_responder #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk(clk), .reset_n(reset_n), .uiDevice(uiDevice), .uiWrtEn(uiWrtEn),
        .uiOut(uiOut), .uiIn(uiIn), .KEY(KEY), .SW(SW),
        .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .LEDR(LEDR)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] d);
        logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return tbl[d];
    endfunction

    function automatic logic [31:0] exp_rd(input logic [1:0] d);
        case (d)
            2'd0:    return {16'h0, m_hex};
            2'd1:    return {22'h0, m_ledr};
            2'd2:    return {24'h0, m_key_hit, m_key_lvl};
            default: return {22'h0, m_sw_lvl};
        endcase
    endfunction

    task automatic model_reset();
        m_hex = '0; m_ledr = '0; m_key_lvl = '0; m_key_hit = '0; m_sw_lvl = '0;
        seen_q = {};
        seen_q.push_back(14'h00F);
        seen_q.push_back(14'h00F);
        for (int i = 0; i < 14; i++) run[i] = 0;
    endtask

    // Applies one clock edge to the model using the inputs present before the edge.
    task automatic model_step();
        logic [13:0] seen, want, cur;
        logic [3:0]  old_key;
        seen = seen_q.pop_front();
        seen_q.push_back({SW, KEY});
        want    = seen ^ 14'h00F;
        cur     = {m_sw_lvl, m_key_lvl};
        old_key = m_key_lvl;
        for (int i = 0; i < 14; i++) begin
            if (want[i] != cur[i]) begin
                run[i]++;
                if (run[i] == DEB) begin
                    cur[i] = want[i];
                    run[i] = 0;
                end
            end else begin
                run[i] = 0;
            end
        end
        if (uiWrtEn) begin
            case (uiDevice)
                2'd0:    m_hex = uiOut[15:0];
                2'd1:    m_ledr = uiOut[9:0];
                2'd2:    m_key_hit = m_key_hit & ~uiOut[7:4];
                default: ;
            endcase
        end
        m_key_lvl = cur[3:0];
        m_sw_lvl  = cur[13:4];
        m_key_hit = m_key_hit | (m_key_lvl & ~old_key);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            if (reset_n) model_step();
            #2;
        end
    endtask

    task automatic assert_reset();
        reset_n = 1'b0;
        model_reset();
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("hex0", {25'h0, HEX0}, {25'h0, glyph(m_hex[3:0])});
            check("hex1", {25'h0, HEX1}, {25'h0, glyph(m_hex[7:4])});
            check("hex2", {25'h0, HEX2}, {25'h0, glyph(m_hex[11:8])});
            check("hex3", {25'h0, HEX3}, {25'h0, glyph(m_hex[15:12])});
            check("ledr", {22'h0, LEDR}, {22'h0, m_ledr});
            check("uiin", uiIn, exp_rd(uiDevice));
        end
    end

    initial begin
        reset_n = 1'b1; uiDevice = 2'd0; uiWrtEn = 1'b0; uiOut = '0;
        KEY = 4'hF; SW = 10'h3FF;
        model_reset();
        #1;
        assert_reset();
        #1;
        check("rst_hex0", {25'h0, HEX0}, 32'h40);
        check("rst_hex3", {25'h0, HEX3}, 32'h40);
        check("rst_ledr", {22'h0, LEDR}, 32'h0);
        for (int d = 0; d < 4; d++) begin
            uiDevice = 2'(d);
            #1 check("rst_read", uiIn, 32'h0);
        end
        chk_on = 1'b1;
        tick(2);
        reset_n  = 1'b1;
        uiDevice = 2'd3;
        tick(5);
        #1 check("sw_before_window", uiIn, 32'h0);
        tick(1);
        #1 check("sw_after_window", uiIn, 32'h3FF);

        uiDevice = 2'd0; uiWrtEn = 1'b1; uiOut = 32'hDEADBEEF;
        tick(1);
        uiWrtEn = 1'b0;
        #1;
        check("hex0_F", {25'h0, HEX0}, 32'h0E);
        check("hex3_B", {25'h0, HEX3}, 32'h03);
        check("hex_read", uiIn, 32'h0000BEEF);

        uiDevice = 2'd1; uiWrtEn = 1'b1; uiOut = 32'hFFFF_F2A5;
        tick(1);
        #1 check("ledr_write", {22'h0, LEDR}, 32'h2A5);
        uiDevice = 2'd3; uiOut = 32'h1;
        tick(1);
        uiWrtEn = 1'b0;
        #1;
        check("ledr_after_sw_wr", {22'h0, LEDR}, 32'h2A5);
        check("sw_after_sw_wr", uiIn, 32'h3FF);

        uiDevice = 2'd2;
        KEY = 4'hB; tick(3);
        KEY = 4'hF; tick(8);
        #1 check("key_glitch", uiIn, 32'h0);
        KEY = 4'hB; tick(5);
        #1 check("key_before_window", uiIn, 32'h0);
        tick(1);
        #1 check("key_press", uiIn, 32'h44);
        tick(4);
        KEY = 4'hF; tick(6);
        #1 check("key_release", uiIn, 32'h40);

        KEY = 4'hB; tick(5);
        uiWrtEn = 1'b1; uiOut = 32'h40;
        tick(1);
        uiWrtEn = 1'b0;
        #1 check("set_beats_clear", uiIn, 32'h44);
        uiWrtEn = 1'b1;
        tick(1);
        uiWrtEn = 1'b0;
        #1 check("write_clear", uiIn, 32'h04);

        uiDevice = 2'd3; SW = 10'h3FE;
        tick(2);
        assert_reset();
        #1;
        check("midrst_sw", uiIn, 32'h0);
        check("midrst_hex0", {25'h0, HEX0}, 32'h40);
        check("midrst_ledr", {22'h0, LEDR}, 32'h0);
        tick(1);
        reset_n = 1'b1;
        tick(5);
        #1 check("midrst_sw_early", uiIn, 32'h0);
        tick(1);
        #1 check("midrst_sw_full", uiIn, 32'h3FE);
        uiDevice = 2'd2;
        #1 check("midrst_key", uiIn, 32'h44);

        for (int c = 0; c < 3000; c++) begin
            uiDevice = 2'($urandom_range(0, 3));
            uiWrtEn  = ($urandom_range(0, 3) == 0);
            uiOut    = $urandom;
            if ($urandom_range(0, 9) == 0) KEY[$urandom_range(0, 3)] ^= 1'b1;
            if ($urandom_range(0, 5) == 0) SW[$urandom_range(0, 9)] ^= 1'b1;
            if ($urandom_range(0, 599) == 0) begin
                assert_reset();
                tick(2);
                reset_n = 1'b1;
            end
            tick(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ui_device_responder.md
Name: ui_device_responder

Overview:
- Board-side responder for the processor's memory-mapped UI bus.
- The IO controller drives device select, write enable and write data. This block answers:
  - latches writes into the HEX and LEDR output registers;
  - synchronises and debounces the KEY and SW pins;
  - keeps sticky key-press flags;
  - returns read data for the selected device on uiIn.
- Sits between the IO controller and the FPGA board pins.

Parameters:
- DBITS, 32, bus data width.
- NKEYS, 4, number of push buttons (max 4).
- NSW, 10, number of slide switches (<= DBITS).
- NLEDR, 10, number of red LEDs (<= DBITS).
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required to accept a pin change (>= 1).
- DEV_HEX, 2'd0, uiDevice code for HEX.
- DEV_LEDR, 2'd1, uiDevice code for LEDR.
- DEV_KEY, 2'd2, uiDevice code for KEY.
- DEV_SW, 2'd3, uiDevice code for SW.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- uiDevice  in  2  selected device code.
- uiWrtEn  in  1  write strobe for the selected device.
- uiOut  in  DBITS  write data.
- uiIn  out  DBITS  read data for the selected device.
- KEY  in  NKEYS  raw push-button pins, active-low (0 = pressed).
- SW  in  NSW  raw switch pins.
- HEX0, HEX1, HEX2, HEX3  out  7 each  seven-segment drives, active-low, bit 0 = segment a.
- LEDR  out  NLEDR  LED drives.

Behaviour:
- Reset (async assert, sync release) clears all state:
  - hexReg = 16'h0, so HEX0..HEX3 = 7'b1000000 ("0");
  - LEDR = 0;
  - KEY synchronisers = 1 (released); SW synchronisers = 0;
  - debounced keyLvl = 0, swLvl = 0;
  - sticky keyHit = 0; debounce counters = 0.
- Reset mid-operation aborts any pending debounce count. After release, a held pin still needs the full debounce window.
- Writes (one cycle, on the clk edge where uiWrtEn = 1):
  - DEV_HEX: hexReg <= uiOut[15:0]. HEXn shows hexReg[4n+3:4n] in hex (0-F, standard glyphs), decoded combinationally from hexReg.
  - DEV_LEDR: LEDR <= uiOut[NLEDR-1:0].
  - DEV_KEY: write-1-to-clear, keyHit[i] <= 0 where uiOut[4+i] = 1.
  - DEV_SW: ignored.
  - No uiWrtEn: no register changes.
- Input path, per bit:
  - Two-flop synchroniser. KEY is inverted after sync, so 1 = pressed.
  - Each bit has its own counter. If sync != stable, counter++; when counter reaches DEBOUNCE_CYCLES-1, stable <= sync and counter <= 0 on that edge.
  - If sync == stable, counter <= 0, so a glitch restarts the count.
  - Pin-to-stable latency for a clean step: DEBOUNCE_CYCLES+2 edges.
  - DEBOUNCE_CYCLES = 1 reduces the path to synchroniser only.
- Sticky flags:
  - keyHit[i] is set on the edge where keyLvl[i] goes 0->1.
  - A release (1->0) does not clear keyHit.
  - If a set and a write-clear hit the same bit on the same edge, set wins.
- Read (combinational from registered state, zero latency, independent of uiWrtEn):
  - DEV_HEX: {zeros, hexReg}.
  - DEV_LEDR: {zeros, LEDR}.
  - DEV_KEY: {zeros, keyHit[NKEYS-1:0] at bits 7:4, keyLvl[NKEYS-1:0] at bits 3:0}; unused bits 0.
  - DEV_SW: {zeros, swLvl}.
  - uiIn never floats; all unused bits 0.
- Width rules: writes truncate uiOut to register width; reads zero-extend to DBITS.

Test Plan (DEBOUNCE_CYCLES = 4 for all):
- Reset with KEY = 4'hF, SW = 10'h3FF held -> immediately HEX0..3 = 7'h40, LEDR = 0, uiIn reads 0 for all devices; 6 edges after reset_n rises, SW read = 32'h3FF.
- Write DEV_HEX, uiOut = 32'hDEADBEEF -> next edge HEX0 = 'F' (7'b0001110), HEX3 = 'B' (7'b0000011), DEV_HEX read = 32'h0000BEEF.
- Write DEV_LEDR 32'hFFFF_F2A5 -> LEDR = 10'h2A5. Then write DEV_SW 32'h1 -> LEDR and SW read unchanged.
- KEY[2] low for 3 cycles then high -> no change, keyHit = 0. KEY[2] low for 10 cycles -> after 6 edges DEV_KEY read = 32'h44. After release and 6 edges, read = 32'h40.
- Write DEV_KEY uiOut = 32'h40 on the same edge keyLvl[2] rises again -> keyHit[2] stays 1. Write-clear on a later edge -> read = 32'h04.
- Assert reset_n = 0 mid-count (2 edges into a SW[0] change) -> all cleared asynchronously; after release the change needs the full 6 edges again.
